// File: rtl/scramble_sequencer.sv
// Issues MOVES random row/column moves spaced GAP+1 clocks apart, then hands the cell
// array over to the user controls and counts user moves until the next start.
module scramble_sequencer #(
  parameter int unsigned MOVES = 16,
  parameter int unsigned GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       user_fire,
  input  logic       user_nRow,
  input  logic [3:0] user_row_column,
  input  logic       user_error,
  input  logic [2:0] rand_in,
  output logic       fire,
  output logic       x_nRow,
  output logic [3:0] row_column,
  output logic       scrambling,
  output logic       done,
  output logic [7:0] move_count
);

  localparam logic [23:0] GapLast   = 24'(GAP - 1);
  localparam logic [7:0]  MovesInit = 8'(MOVES);

  typedef enum logic [1:0] {StGap, StFire, StPlay} state_e;

  state_e      state_q, state_d;
  logic [23:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  moves_left_q, moves_left_d;
  logic        nrow_q, nrow_d;
  logic [1:0]  target_q, target_d;
  logic        prev_q;
  logic [7:0]  move_count_q, move_count_d;
  logic        user_edge;

  // An edge masked by user_error is lost: prev still tracks the level.
  assign user_edge  = user_fire & ~prev_q & ~user_error;
  assign move_count = move_count_q;

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    moves_left_d = moves_left_q;
    nrow_d       = nrow_q;
    target_d     = target_q;
    move_count_d = move_count_q;
    fire         = 1'b0;
    done         = 1'b0;
    scrambling   = 1'b1;
    x_nRow       = nrow_q;
    row_column   = 4'b0001 << target_q;

    unique case (state_q)
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = StFire;
          nrow_d    = rand_in[2];
          target_d  = rand_in[1:0];
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 24'd1;
        end
      end
      StFire: begin
        fire         = 1'b1;
        moves_left_d = moves_left_q - 8'd1;
        if (moves_left_q == 8'd1) begin
          done    = 1'b1;
          state_d = StPlay;
        end else begin
          state_d = StGap;
        end
      end
      StPlay: begin
        scrambling = 1'b0;
        x_nRow     = user_nRow;
        row_column = user_row_column;
        fire       = user_edge;
        if (start) begin
          state_d      = StGap;
          moves_left_d = MovesInit;
          gap_cnt_d    = '0;
          move_count_d = '0;
        end else if (user_edge && (move_count_q != 8'hff)) begin
          move_count_d = move_count_q + 8'd1;
        end
      end
      default: state_d = StGap;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StGap;
      gap_cnt_q    <= '0;
      moves_left_q <= MovesInit;
      nrow_q       <= 1'b0;
      target_q     <= 2'b00;
      prev_q       <= 1'b1;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      moves_left_q <= moves_left_d;
      nrow_q       <= nrow_d;
      target_q     <= target_d;
      prev_q       <= user_fire;
      move_count_q <= move_count_d;
    end
  end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Bench for scramble_sequencer: scramble-timeline model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_scramble_sequencer;

  localparam int TbGap   = 4;
  localparam int TbMoves = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       user_fire = 1'b0;
  logic       user_nRow = 1'b0;
  logic [3:0] user_row_column = 4'b0001;
  logic       user_error = 1'b0;
  logic [2:0] rand_in = 3'b110;
  logic       fire, x_nRow, scrambling, done;
  logic [3:0] row_column;
  logic [7:0] move_count;

  int n_checks = 0;
  int n_fail   = 0;

  scramble_sequencer #(.MOVES(TbMoves), .GAP(TbGap)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .user_fire       (user_fire),
    .user_nRow       (user_nRow),
    .user_row_column (user_row_column),
    .user_error      (user_error),
    .rand_in         (rand_in),
    .fire            (fire),
    .x_nRow          (x_nRow),
    .row_column      (row_column),
    .scrambling      (scrambling),
    .done            (done),
    .move_count      (move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a scramble is a timeline of cycles t=0,1,...; cycle t fires when (t+1) is a
  // multiple of GAP+1, and the target is sampled on the edge entering that cycle.
  logic       m_scr = 1'b1;
  int         m_t = 0;
  logic       m_nrow = 1'b0;
  logic [1:0] m_tgt = 2'b00;
  logic       m_prev = 1'b1;
  int         m_mc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_scr <= 1'b1; m_t <= 0; m_nrow <= 1'b0; m_tgt <= 2'b00; m_prev <= 1'b1; m_mc <= 0;
    end else begin
      if (m_scr) begin
        if ((m_t + 1) % (TbGap + 1) == TbGap) begin
          m_nrow <= rand_in[2];
          m_tgt  <= rand_in[1:0];
        end
        if ((m_t + 1) % (TbGap + 1) == 0 && (m_t + 1) / (TbGap + 1) == TbMoves) m_scr <= 1'b0;
        m_t <= m_t + 1;
      end else if (start) begin
        m_scr <= 1'b1; m_t <= 0; m_mc <= 0;
      end else if (user_fire && !m_prev && !user_error && m_mc < 255) begin
        m_mc <= m_mc + 1;
      end
      m_prev <= user_fire;
    end
  end

  always @(negedge clk) begin : compare
    logic e_fire, e_done, e_xn;
    logic [3:0] e_rc;
    if (m_scr) begin
      e_fire = ((m_t + 1) % (TbGap + 1) == 0);
      e_done = e_fire && ((m_t + 1) / (TbGap + 1) == TbMoves);
      e_xn   = m_nrow;
      e_rc   = 4'b0001 << m_tgt;
    end else begin
      e_fire = user_fire & ~m_prev & ~user_error;
      e_done = 1'b0;
      e_xn   = user_nRow;
      e_rc   = user_row_column;
    end
    chk("model fire", int'(fire), int'(e_fire));
    chk("model done", int'(done), int'(e_done));
    chk("model x_nRow", int'(x_nRow), int'(e_xn));
    chk("model row_column", int'(row_column), int'(e_rc));
    chk("model scrambling", int'(scrambling), int'(m_scr));
    chk("model move_count", int'(move_count), m_mc);
  end

  // Pulse log: clock index (relative to mark) on which each fire pulse is sampled.
  int edge_n = 0;
  int mark = 0;
  int n_pulses = 0;
  int pulse_rel [64];
  logic pulse_xn [64];
  logic [3:0] pulse_rc [64];
  logic pulse_done [64];

  always @(posedge clk or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (fire) begin
      if (n_pulses < 64) begin
        pulse_rel[n_pulses]  = edge_n + 1 - mark;
        pulse_xn[n_pulses]   = x_nRow;
        pulse_rc[n_pulses]   = row_column;
        pulse_done[n_pulses] = done;
      end
      n_pulses++;
    end
  end

  task automatic chk_scramble(input string tag, input int base);
    int exp_p [3];
    exp_p = '{5, 10, 15};
    chk({tag, " pulse count"}, n_pulses - base, 3);
    for (int i = 0; i < 3; i++) chk({tag, " pulse clock"}, pulse_rel[base + i], exp_p[i]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " fire"}, int'(fire), 0);
    chk({tag, " x_nRow"}, int'(x_nRow), 0);
    chk({tag, " row_column"}, int'(row_column), 1);
    chk({tag, " scrambling"}, int'(scrambling), 1);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " move_count"}, int'(move_count), 0);
  endtask

  initial begin
    int base;
    #2 reset = 1'b0;
    step(3);
    chk_reset_outputs("reset");

    // First scramble after reset release, rand_in=110.
    reset = 1'b1;
    mark  = 0;
    base  = n_pulses;
    step(20);
    chk_scramble("boot", base);
    for (int i = 0; i < 3; i++) begin
      chk("boot pulse x_nRow", int'(pulse_xn[base + i]), 1);
      chk("boot pulse row_column", int'(pulse_rc[base + i]), 4);
    end
    chk("boot done on 1st", int'(pulse_done[base]), 0);
    chk("boot done on 3rd", int'(pulse_done[base + 2]), 1);
    chk("boot scrambling after", int'(scrambling), 0);

    // Three user edges.
    user_nRow = 1'b0;
    user_row_column = 4'b0010;
    base = n_pulses;
    for (int i = 0; i < 3; i++) begin
      user_fire = 1'b1; step(1);
      user_fire = 1'b0; step(1);
    end
    chk("play pulses", n_pulses - base, 3);
    chk("play pulse row_column", int'(pulse_rc[base + 1]), 2);
    chk("play move_count", int'(move_count), 3);

    // Edge under user_error is discarded, not deferred.
    base = n_pulses;
    user_error = 1'b1; user_fire = 1'b1; step(2);
    user_error = 1'b0; step(2);
    user_fire = 1'b0; step(1);
    chk("error pulses", n_pulses - base, 0);
    chk("error move_count", int'(move_count), 3);

    for (int i = 0; i < 4; i++) begin
      user_fire = 1'b1; step(1);
      user_fire = 1'b0; step(1);
    end
    chk("seven moves", int'(move_count), 7);

    // Start from PLAY, with a stray start mid-scramble and user_fire held through the end.
    start = 1'b1;
    mark  = edge_n + 1;
    base  = n_pulses;
    step(1);
    start = 1'b0;
    chk("start move_count", int'(move_count), 0);
    chk("start scrambling", int'(scrambling), 1);
    for (int i = 0; i < 20; i++) begin
      rand_in = 3'($urandom_range(0, 7));
      start = (i == 7);
      if (i == 10) user_fire = 1'b1;
      step(1);
    end
    start = 1'b0;
    chk_scramble("restart", base);
    step(4);
    chk("held fire no pulse", n_pulses - base, 3);
    user_fire = 1'b0; step(1);
    user_fire = 1'b1; step(1);
    user_fire = 1'b0; step(1);
    chk("re-edge pulse", n_pulses - base, 4);
    chk("re-edge move_count", int'(move_count), 1);

    // Start and user edge together: pulse issued, count cleared.
    rand_in = 3'b110;
    start = 1'b1; user_fire = 1'b1;
    mark = edge_n + 1;
    base = n_pulses;
    step(1);
    start = 1'b0; user_fire = 1'b0;
    chk("start+fire pulse", n_pulses - base, 1);
    chk("start+fire move_count", int'(move_count), 0);
    chk("start+fire scrambling", int'(scrambling), 1);

    // Reset between the 2nd and 3rd scramble pulses.
    step(12);
    chk("pre-reset pulses", n_pulses - base, 3);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    step(2);
    reset = 1'b1;
    mark = 0;
    base = n_pulses;
    step(20);
    chk_scramble("after reset", base);

    // Saturation at 255.
    for (int i = 0; i < 256; i++) begin
      user_fire = 1'b1; step(1);
      user_fire = 1'b0; step(1);
    end
    chk("saturated move_count", int'(move_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scramble_sequencer.md
SCRAMBLE_SEQUENCER -- requirements
Module: scramble_sequencer

Interface
REQ-001 The block SHALL have parameter MOVES, default 16, meaning the number of random moves per scramble (range 1..255).
REQ-002 The block SHALL have parameter GAP, default 4, meaning the idle clocks between scramble fire pulses (range 1..2^24-1).
REQ-003 The block SHALL have port clk  input  1  system clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  single-cycle request to begin a new scramble.
REQ-006 The block SHALL have port user_fire  input  1  debounced fire-button level.
REQ-007 The block SHALL have port user_nRow  input  1  user select, 0=row, 1=column.
REQ-008 The block SHALL have port user_row_column  input  4  user one-hot row/column select.
REQ-009 The block SHALL have port user_error  input  1  high when the user switch setting is not one-hot.
REQ-010 The block SHALL have port rand_in  input  3  free-running random value from the random generator.
REQ-011 The block SHALL have port fire  output  1  single-cycle move strobe to the cell array.
REQ-012 The block SHALL have port x_nRow  output  1  row/column select to the cell array.
REQ-013 The block SHALL have port row_column  output  4  one-hot target to the cell array.
REQ-014 The block SHALL have port scrambling  output  1  high while a scramble is in progress.
REQ-015 The block SHALL have port done  output  1  single-cycle pulse when the scramble completes.
REQ-016 The block SHALL have port move_count  output  8  user moves since the last scramble ended.

Function
REQ-017 The FSM SHALL have exactly three states:
- GAP: idle wait between scramble moves.
- FIRE: issue one scramble move.
- PLAY: pass user controls through.
REQ-018 GAP SHALL count gap_cnt from 0; when gap_cnt==GAP-1 the FSM SHALL go to FIRE, latch rand_in[2] into the nRow register and rand_in[1:0] into the target register, and clear gap_cnt.
REQ-019 In FIRE, fire SHALL be 1 for exactly one cycle, and moves_left SHALL decrement.
REQ-020 On leaving FIRE: if moves_left was 1, next state SHALL be PLAY with done=1 for that one cycle; otherwise next state SHALL be GAP.
REQ-021 Scramble fire pulses SHALL be spaced exactly GAP+1 clocks apart; exactly MOVES pulses SHALL be issued per scramble.
REQ-022 In GAP/FIRE, row_column SHALL be the one-hot decode of the latched target (00->0001, 01->0010, 10->0100, 11->1000), and x_nRow SHALL equal the latched nRow; both SHALL be stable from the latch until the next latch.
REQ-023 scrambling SHALL be 1 in GAP and FIRE, and 0 in PLAY.
REQ-024 In PLAY, x_nRow SHALL equal user_nRow and row_column SHALL equal user_row_column, combinationally.
REQ-025 An edge register prev SHALL sample user_fire every cycle in all states.
REQ-026 In PLAY, fire SHALL be user_fire & ~prev & ~user_error, giving one pulse per 0->1 edge.
REQ-027 An edge suppressed by user_error SHALL be discarded, not deferred.
REQ-028 A user_fire level held high across the FIRE->PLAY transition SHALL NOT produce a fire pulse.
REQ-029 move_count SHALL increment on each PLAY fire pulse and saturate at 255.
REQ-030 start in PLAY SHALL, on the next edge:
- go to GAP;
- reload moves_left=MOVES;
- clear gap_cnt;
- clear move_count.
REQ-031 start in GAP or FIRE SHALL be ignored.
REQ-032 start and a user fire edge in the same PLAY cycle SHALL produce the fire pulse, and move_count SHALL be cleared rather than incremented.

Reset
REQ-033 While reset=0, the block SHALL asynchronously force:
- state=GAP, gap_cnt=0, moves_left=MOVES;
- latched nRow=0, latched target=00;
- prev=1, move_count=0.
REQ-034 During reset, outputs SHALL be fire=0, x_nRow=0, row_column=0001, scrambling=1, done=0, move_count=0.
REQ-035 On reset release, a scramble SHALL start automatically; the first fire pulse SHALL occur GAP+1 clocks after the first rising edge with reset=1.
REQ-036 Reset asserted mid-scramble or mid-PLAY SHALL abandon the operation and restart per REQ-033..035.

Verification
REQ-037 GAP=4, MOVES=3; release reset with rand_in=3'b110 -> fire pulses on clocks 5, 10 and 15; x_nRow=1 and row_column=0100 at each pulse; done=1 on clock 15; scrambling falls after clock 15.
REQ-038 In PLAY, toggle user_fire 0->1->0 three times with user_error=0 -> three single-cycle fire pulses, each with row_column=user_row_column; move_count=3.
REQ-039 In PLAY, apply user_error=1 with a user_fire rising edge -> fire=0 and move_count unchanged; holding user_fire high after user_error clears -> still no pulse.
REQ-040 Hold user_fire=1 through the end of a scramble -> no PLAY fire pulse until user_fire drops and rises again.
REQ-041 Pulse start in PLAY with move_count=7 -> move_count=0 and scrambling=1 next cycle; a start pulsed mid-scramble -> pulse count and spacing unchanged.
REQ-042 Assert reset between the 2nd and 3rd scramble pulses -> outputs immediately take their reset values, and pulse timing restarts from clock 5.
REQ-043 With move_count=255, apply a further PLAY fire -> move_count stays 255.
